// File: rtl/alu_result_disp.sv
// alu_result_disp: registered display stage for the 4-bit ALU result.
// Captures {res, car, of, mode} on in_valid && in_ready. It holds each
// result for HOLD_CYCLES before accepting the next one. It drives two
// active-low seven-segment digits and three flag LEDs.
// Optional feature: define ALU_DISP_BLINK_EN to blink overflow results
// with a half-period of BLINK_HALF cycles.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid       upstream result present
//   in_ready       capture accepted this cycle (registered)
//   res, car, of   ALU result and flags
//   ctrl           ALU opcode; 000/001 select signed display, others hex
//   seg0           low digit, active-low {dp,g,f,e,d,c,b,a}, dp always off
//   seg1           high digit: minus sign or blank
//   led            {of, car, shown}
module alu_result_disp #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned BLINK_HALF  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] res,
    input  logic       car,
    input  logic       of,
    input  logic [2:0] ctrl,
    output logic [7:0] seg0,
    output logic [7:0] seg1,
    output logic [2:0] led
);

    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] SHOW = 2'd2;

    localparam logic [7:0] BLANK = 8'hFF;
    localparam logic [7:0] MINUS = 8'hBF;

    // Elaboration-time parameter range checks
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be at least 1");
    end
    if (BLINK_HALF < 1) begin : g_bad_blink
        $error("BLINK_HALF must be at least 1");
    end

    // Active-low hex glyph lookup
    function automatic logic [7:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            default: glyph = 8'h8E;
        endcase
    endfunction

    logic [1:0]    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [3:0]    res_q, res_d;
    logic          car_q, car_d;
    logic          of_q, of_d;
    logic          sgn_q, sgn_d;
    logic          ready_d;
    logic [7:0]    seg0_d, seg1_d;
    logic [2:0]    led_d;
    logic [3:0]    mag;
    logic [7:0]    glyph_sel;
    logic          capture_c;
    logic          blank_c;

    assign capture_c = in_valid && in_ready;

    // Next-state, capture and display computation
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        res_d   = res_q;
        car_d   = car_q;
        of_d    = of_q;
        sgn_d   = sgn_q;

        case (state)
            IDLE, SHOW: begin
                if (capture_c) begin
                    state_d = HOLD;
                    cnt_d   = CW'(HOLD_CYCLES - 1);
                    res_d   = res;
                    car_d   = car;
                    of_d    = of;
                    sgn_d   = (ctrl[2:1] == 2'b00);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_d = SHOW;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d != HOLD);

        // Two's-complement magnitude; 4'b1000 maps to 8
        mag       = res_d[3] ? 4'(~res_d + 4'd1) : res_d;
        glyph_sel = sgn_d ? glyph(mag) : glyph(res_d);

        seg0_d = BLANK;
        seg1_d = BLANK;
        led_d  = 3'b000;
        if (state_d != IDLE) begin
            led_d = {of_d, car_d, 1'b1};
            if (!blank_c) begin
                seg0_d = glyph_sel;
                seg1_d = (sgn_d && res_d[3]) ? MINUS : BLANK;
            end
        end
    end

`ifdef ALU_DISP_BLINK_EN
    localparam int unsigned BW = $clog2(BLINK_HALF + 1);

    logic [BW-1:0] bcnt, bcnt_d;
    logic          phase, phase_d;

    // Blink phase: restarts on capture with the glyph phase first
    always_comb begin
        bcnt_d  = bcnt;
        phase_d = phase;
        if (capture_c || state_d == IDLE) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (bcnt == BW'(BLINK_HALF - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase;
        end else begin
            bcnt_d = bcnt + BW'(1);
        end
        blank_c = of_d && phase_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else begin
            bcnt  <= bcnt_d;
            phase <= phase_d;
        end
    end
`else
    assign blank_c = 1'b0;
`endif

    // State, captured result and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            res_q    <= '0;
            car_q    <= 1'b0;
            of_q     <= 1'b0;
            sgn_q    <= 1'b0;
            in_ready <= 1'b0;
            seg0     <= BLANK;
            seg1     <= BLANK;
            led      <= 3'b000;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            res_q    <= res_d;
            car_q    <= car_d;
            of_q     <= of_d;
            sgn_q    <= sgn_d;
            in_ready <= ready_d;
            seg0     <= seg0_d;
            seg1     <= seg1_d;
            led      <= led_d;
        end
    end

endmodule

// File: tb/tb_alu_result_disp.sv
// Self-checking bench for alu_result_disp with a cycle-level reference model.
module tb_alu_result_disp;

    localparam int HOLD  = 4;
    localparam int BLINK = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] res = '0;
    logic       car = 1'b0;
    logic       of = 1'b0;
    logic [2:0] ctrl = '0;
    logic [7:0] seg0, seg1;
    logic [2:0] led;

    int checks = 0;
    int errors = 0;

    alu_result_disp #(.HOLD_CYCLES(HOLD), .BLINK_HALF(BLINK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .res(res), .car(car), .of(of), .ctrl(ctrl),
        .seg0(seg0), .seg1(seg1), .led(led)
    );

    always #5 clk = ~clk;

    logic [7:0] glyph_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: what was captured and how many cycles ago
    bit         m_have = 0;
    bit         m_ready = 0;
    int         m_age = 0;
    logic [3:0] m_res;
    logic       m_car, m_of;
    logic [2:0] m_ctrl;
    int         cyc = 0;
    logic [7:0] e_seg0, e_seg1;
    logic [2:0] e_led;
    logic       e_ready;

    task automatic compute_expected();
        int v, mag;
        e_ready = m_ready;
        if (!m_have) begin
            e_seg0 = 8'hFF; e_seg1 = 8'hFF; e_led = 3'b000;
        end else begin
            e_led = {m_of, m_car, 1'b1};
            if (m_ctrl < 3'd2) begin
                v   = (m_res >= 4'd8) ? int'(m_res) - 16 : int'(m_res);
                mag = (v < 0) ? -v : v;
                e_seg0 = glyph_tbl[mag];
                e_seg1 = (v < 0) ? 8'hBF : 8'hFF;
            end else begin
                e_seg0 = glyph_tbl[m_res];
                e_seg1 = 8'hFF;
            end
`ifdef ALU_DISP_BLINK_EN
            if (m_of && ((m_age / BLINK) % 2 == 1)) begin
                e_seg0 = 8'hFF; e_seg1 = 8'hFF;
            end
`endif
        end
    endtask

    // Advance one clock; update the model with the inputs seen at the edge
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_have = 0; m_ready = 0; m_age = 0;
        end else begin
            if (in_valid && m_ready) begin
                m_have = 1; m_age = 0;
                m_res = res; m_car = car; m_of = of; m_ctrl = ctrl;
            end else if (m_have) begin
                m_age++;
            end
            m_ready = !m_have || (m_age >= HOLD);
        end
        cyc++;
        #1;
        compute_expected();
    endtask

    task automatic do_capture(input logic [3:0] r, input logic c, input logic o, input logic [2:0] ct);
        int n = 0;
        res = r; car = c; of = o; ctrl = ct; in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL capture_wait in_ready got %b required 1 after %0d cycles", in_ready, n);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks += 4;
        if (seg0 !== 8'hFF)  begin errors++; $display("FAIL reset seg0 got %h required ff", seg0); end
        if (seg1 !== 8'hFF)  begin errors++; $display("FAIL reset seg1 got %h required ff", seg1); end
        if (led !== 3'b000)  begin errors++; $display("FAIL reset led got %b required 000", led); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready got %b required 0", in_ready); end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release in_ready got %b required 1", in_ready); end
    endtask

    task automatic test_basic();
        int low = 0;
        res = 4'h3; ctrl = 3'b000; car = 1'b0; of = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks += 3;
        if (seg1 !== 8'hFF)  begin errors++; $display("FAIL basic seg1 got %h required ff", seg1); end
        if (seg0 !== 8'hB0)  begin errors++; $display("FAIL basic seg0 got %h required b0", seg0); end
        if (led !== 3'b001)  begin errors++; $display("FAIL basic led got %b required 001", led); end
        while (in_ready === 1'b0 && low < 20) begin
            low++;
            tick();
        end
        checks++;
        if (low != HOLD) begin errors++; $display("FAIL basic_ready_low cycles got %0d required %0d", low, HOLD); end
    endtask

    task automatic test_signed();
        do_capture(4'hD, 1'b0, 1'b0, 3'b000);
        checks += 2;
        if (seg1 !== 8'hBF) begin errors++; $display("FAIL signed_neg3 seg1 got %h required bf", seg1); end
        if (seg0 !== 8'hB0) begin errors++; $display("FAIL signed_neg3 seg0 got %h required b0", seg0); end
        do_capture(4'h8, 1'b1, 1'b1, 3'b001);
        checks += 3;
        if (seg1 !== 8'hBF) begin errors++; $display("FAIL signed_neg8 seg1 got %h required bf", seg1); end
        if (seg0 !== 8'h80) begin errors++; $display("FAIL signed_neg8 seg0 got %h required 80", seg0); end
        if (led !== 3'b111) begin errors++; $display("FAIL signed_neg8 led got %b required 111", led); end
    endtask

    task automatic test_hex();
        do_capture(4'hA, 1'b0, 1'b0, 3'b011);
        checks += 3;
        if (seg1 !== 8'hFF) begin errors++; $display("FAIL hex seg1 got %h required ff", seg1); end
        if (seg0 !== 8'h88) begin errors++; $display("FAIL hex seg0 got %h required 88", seg0); end
        if (led !== 3'b001) begin errors++; $display("FAIL hex led got %b required 001", led); end
    endtask

    task automatic test_blink();
        do_capture(4'($urandom_range(0, 15)), 1'($urandom), 1'b1, 3'($urandom_range(0, 7)));
        for (int i = 0; i < 12; i++) begin
            res = 4'($urandom); ctrl = 3'($urandom); of = 1'($urandom); car = 1'($urandom);
            checks += 4;
            if (seg0 !== e_seg0) begin errors++; $display("FAIL blink seg0 age %0d got %h required %h", m_age, seg0, e_seg0); end
            if (seg1 !== e_seg1) begin errors++; $display("FAIL blink seg1 age %0d got %h required %h", m_age, seg1, e_seg1); end
            if (led !== e_led)   begin errors++; $display("FAIL blink led age %0d got %b required %b", m_age, led, e_led); end
            if (in_ready !== e_ready) begin errors++; $display("FAIL blink in_ready age %0d got %b required %b", m_age, in_ready, e_ready); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int last_cap = -1;
        bit prev_ready;
        in_valid = 1'b1;
        prev_ready = in_ready;
        for (int i = 0; i < 40; i++) begin
            res = 4'($urandom); car = 1'($urandom); of = 1'($urandom); ctrl = 3'($urandom);
            tick();
            if (prev_ready) begin
                if (last_cap >= 0) begin
                    checks++;
                    if (cyc - last_cap != HOLD + 1) begin
                        errors++;
                        $display("FAIL b2b_spacing got %0d required %0d", cyc - last_cap, HOLD + 1);
                    end
                end
                last_cap = cyc;
            end
            prev_ready = in_ready;
            checks += 4;
            if (seg0 !== e_seg0) begin errors++; $display("FAIL b2b seg0 cyc %0d got %h required %h", cyc, seg0, e_seg0); end
            if (seg1 !== e_seg1) begin errors++; $display("FAIL b2b seg1 cyc %0d got %h required %h", cyc, seg1, e_seg1); end
            if (led !== e_led)   begin errors++; $display("FAIL b2b led cyc %0d got %b required %b", cyc, led, e_led); end
            if (in_ready !== e_ready) begin errors++; $display("FAIL b2b in_ready cyc %0d got %b required %b", cyc, in_ready, e_ready); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_show_persist();
        do_capture(4'h6, 1'b1, 1'b0, 3'b101);
        for (int i = 0; i < 20; i++) begin
            res = 4'($urandom); car = 1'($urandom); of = 1'($urandom); ctrl = 3'($urandom);
            tick();
        end
        checks += 4;
        if (seg0 !== 8'h82)  begin errors++; $display("FAIL persist seg0 got %h required 82", seg0); end
        if (seg1 !== 8'hFF)  begin errors++; $display("FAIL persist seg1 got %h required ff", seg1); end
        if (led !== 3'b011)  begin errors++; $display("FAIL persist led got %b required 011", led); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL persist in_ready got %b required 1", in_ready); end
    endtask

    task automatic test_reset_mid_hold();
        do_capture(4'h5, 1'b0, 1'b0, 3'b100);
        tick();
        rst = 1'b1;
        tick();
        checks += 4;
        if (seg0 !== 8'hFF)  begin errors++; $display("FAIL midrst seg0 got %h required ff", seg0); end
        if (seg1 !== 8'hFF)  begin errors++; $display("FAIL midrst seg1 got %h required ff", seg1); end
        if (led !== 3'b000)  begin errors++; $display("FAIL midrst led got %b required 000", led); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst in_ready got %b required 0", in_ready); end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release in_ready got %b required 1", in_ready); end
        do_capture(4'h7, 1'b0, 1'b0, 3'b000);
        checks += 3;
        if (seg0 !== 8'hF8)  begin errors++; $display("FAIL midrst_recap seg0 got %h required f8", seg0); end
        if (seg1 !== 8'hFF)  begin errors++; $display("FAIL midrst_recap seg1 got %h required ff", seg1); end
        if (led !== 3'b001)  begin errors++; $display("FAIL midrst_recap led got %b required 001", led); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'($urandom);
            res = 4'($urandom); car = 1'($urandom); of = 1'($urandom); ctrl = 3'($urandom);
            tick();
            checks += 4;
            if (seg0 !== e_seg0) begin errors++; $display("FAIL random seg0 cyc %0d got %h required %h", cyc, seg0, e_seg0); end
            if (seg1 !== e_seg1) begin errors++; $display("FAIL random seg1 cyc %0d got %h required %h", cyc, seg1, e_seg1); end
            if (led !== e_led)   begin errors++; $display("FAIL random led cyc %0d got %b required %b", cyc, led, e_led); end
            if (in_ready !== e_ready) begin errors++; $display("FAIL random in_ready cyc %0d got %b required %b", cyc, in_ready, e_ready); end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_hex();
        test_blink();
        test_back_to_back();
        test_show_persist();
        test_reset_mid_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_result_disp.md
# alu_result_disp

Registered display stage directly downstream of the 4-bit ALU. It captures one ALU result (`res`, `car`, `of`) together with the opcode that produced it, using a valid/ready handshake. It drives two active-low seven-segment digits and three flag LEDs. Each captured result is held stable for a programmable minimum time, and overflow results can optionally blink.

## Interface
- `HOLD_CYCLES`, default 4: minimum cycles a new result stays displayed before the next capture is accepted; legal range ≥1.
- `BLINK_HALF`, default 2: half-period of the overflow blink, in cycles; legal range ≥1.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  ALU result present.
- `in_ready`  out  1  stage accepts a capture this cycle.
- `res`  in  4  ALU result.
- `car`  in  1  ALU carry flag.
- `of`  in  1  ALU overflow flag.
- `ctrl`  in  3  ALU opcode that produced `res`.
- `seg0`  out  8  low digit, active-low; bit0=a … bit6=g, bit7=dp (always 1).
- `seg1`  out  8  high digit: sign, or blank.
- `led`  out  3  {of, car, shown}.

## Operation
- Capture occurs when `in_valid && in_ready`. The stage registers `res`, `car`, `of`, and `mode`, where `mode` = signed when `ctrl` ∈ {000, 001} and hex otherwise.
- States:
  - IDLE: nothing shown; `in_ready`=1; a capture moves to HOLD.
  - HOLD: `in_ready`=0; the counter is loaded with HOLD_CYCLES-1 and decrements each cycle; the state moves to SHOW when the counter reaches 0.
  - SHOW: `in_ready`=1; the display persists; a capture moves to HOLD.
- Signed mode:
  - `res` is 4-bit two's complement.
  - `seg1` = 8'hBF (minus) if res[3]=1, else 8'hFF.
  - `seg0` = digit(|res|), with magnitude 0..8. The case res=4'b1000 shows minus and 8.
- Hex mode:
  - `seg1` = 8'hFF.
  - `seg0` = hex glyph of `res`.
- Glyphs for 0–F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- `led` = {of_q, car_q, shown}. `shown`=1 in HOLD and SHOW.
- In IDLE, `seg0` = `seg1` = 8'hFF and `led` = 3'b000.
- Inputs are sampled only at the capture edge; changes to `res`, `car`, `of`, or `ctrl` at any other time are ignored.

## Timing
- Capture at edge k → new `seg0`, `seg1`, and `led` are visible after edge k (1-cycle latency). All outputs are registered.
- `in_ready` is a function of the registered state only, with no combinational path from `in_valid`. It is low for exactly HOLD_CYCLES cycles after each capture.
- Back-to-back operation: with `in_valid` held high, captures occur every HOLD_CYCLES+1 cycles.
- `in_valid` low while in SHOW leaves the display unchanged indefinitely.
- Reset:
  - While `rst`=1, the block goes to IDLE: `seg0`=`seg1`=8'hFF, `led`=0, `in_ready`=0, counters 0.
  - `in_ready`=1 on the first cycle after `rst` falls.
  - Reset asserted mid-HOLD aborts the hold and blanks the display on the next edge.
- `in_valid` during HOLD is not accepted. The upstream stage holds its data until `in_ready`.

## Configuration
- `ALU_DISP_BLINK_EN` defined:
  - When `of_q`=1 in HOLD or SHOW, `seg0` and `seg1` alternate between the glyph and 8'hFF every BLINK_HALF cycles.
  - The phase restarts at each capture, with the glyph phase first.
  - `led` does not blink.
  - The blink counter width is $clog2(BLINK_HALF+1).
- `ALU_DISP_BLINK_EN` undefined: no blink logic; an overflow result is displayed steadily. All other behaviour is identical.

## Test plan
- Reset, then `in_valid`=1, `res`=4'h3, `ctrl`=000, `car`=0, `of`=0 → one cycle later `seg1`=FF, `seg0`=B0, `led`=001; `in_ready`=0 for 4 cycles, then 1.
- Capture `res`=4'hD, `ctrl`=000 → `seg1`=BF, `seg0`=B0 (−3). Capture `res`=4'h8, `ctrl`=001, `of`=1, `car`=1 → `seg1`=BF, `seg0`=80, `led`=111.
- Capture `res`=4'hA, `ctrl`=011 → `seg1`=FF, `seg0`=88. Then `in_valid` held 1 with the value changing every cycle → captures occur only every 5 cycles, and each displayed value matches the value present at its capture edge.
- With `ALU_DISP_BLINK_EN`, capture an `of`=1 result → `seg0` = glyph for 2 cycles, FF for 2 cycles, repeating. Without the macro → steady glyph.
- Assert `rst` at the 2nd HOLD cycle → next edge: `seg0`=`seg1`=FF, `led`=0, `in_ready`=0. After release, `in_ready`=1 and a new capture proceeds normally.
